// File: rtl/bram_sdp_1ck_be.sv
// Simple dual-port, single-clock block RAM with byte-lane write enables, 1- or 2-cycle read
// latency, a selectable same-address collision policy and an optional zeroisation sweep after reset.
module bram_sdp_1ck_be #(
    parameter int    DATA_WIDTH     = 64,
    parameter int    BYTE_WIDTH     = 8,
    parameter int    DEPTH          = 512,
    parameter int    READ_LATENCY   = 2,
    parameter string COLLISION      = "WRITE_FIRST",
    parameter bit    CLEAR_ON_RESET = 1'b1,
    localparam int   NUM_BYTES      = DATA_WIDTH / BYTE_WIDTH,
    localparam int   ADDR_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam bit                WRITE_FIRST = (COLLISION == "WRITE_FIRST");
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W     = (ADDR_W + 1)'(DEPTH);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("bram_sdp_1ck_be: READ_LATENCY must be 1 or 2");
        end
        if (COLLISION != "WRITE_FIRST" && COLLISION != "READ_FIRST") begin : g_bad_collision
            $error("bram_sdp_1ck_be: COLLISION must be WRITE_FIRST or READ_FIRST");
        end
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("bram_sdp_1ck_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_nxt;
    logic              w_clr_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_nxt   = ST_READY;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    assign init_busy = (r_state == ST_CLEAR) || !rst_n;

    logic w_ready;
    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_fire;
    logic w_rd_fire;
    logic w_collide;

    assign w_ready       = (r_state == ST_READY);
    assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign w_rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign w_wr_fire     = rst_n && w_ready && wr_en && w_wr_in_range && (|wr_be);
    assign w_rd_fire     = rst_n && w_ready && rd_en;
    // Forwarding rather than BRAM write-first mode keeps the per-lane merge exact.
    assign w_collide     = WRITE_FIRST && w_wr_fire && w_rd_in_range && (rd_addr == wr_addr);

    // The sweep and user writes share the single write port.
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_waddr;
    logic [NUM_BYTES-1:0]  w_mem_wbe;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign w_mem_we    = (rst_n && w_clr_we) || w_wr_fire;
    assign w_mem_waddr = w_clr_we ? r_clr_cnt : wr_addr;
    assign w_mem_wbe   = w_clr_we ? {NUM_BYTES{1'b1}} : wr_be;
    assign w_mem_wdata = w_clr_we ? '0 : wr_data;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; the post-reset sweep clears it instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_mem_wbe[i]) begin
                    r_mem[w_mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [ADDR_W-1:0]     w_rd_idx;
    logic [DATA_WIDTH-1:0] r_mem_q;

    assign w_rd_idx = w_rd_in_range ? rd_addr : '0;

    // Array output register; a same-edge write is not yet visible, giving the old word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_q <= '0;
        end else if (w_rd_fire) begin
            r_mem_q <= r_mem[w_rd_idx];
        end
    end

    logic                  r_v1;
    logic                  r_oor1;
    logic [NUM_BYTES-1:0]  r_fwd_be1;
    logic [DATA_WIDTH-1:0] r_fwd_data1;
    logic [DATA_WIDTH-1:0] w_rd_data1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_oor1      <= 1'b0;
            r_fwd_be1   <= '0;
            r_fwd_data1 <= '0;
        end else begin
            r_v1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_oor1      <= !w_rd_in_range;
                r_fwd_be1   <= w_collide ? wr_be : '0;
                r_fwd_data1 <= wr_data;
            end
        end
    end

    always_comb begin
        w_rd_data1 = r_mem_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_fwd_be1[i]) begin
                w_rd_data1[i*BYTE_WIDTH +: BYTE_WIDTH] = r_fwd_data1[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        if (r_oor1) begin
            w_rd_data1 = '0;
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rd_data  = w_rd_data1;
            assign rd_valid = r_v1;
        end else begin : g_lat2
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_rd_data2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_v2       <= 1'b0;
                    r_rd_data2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_rd_data2 <= w_rd_data1;
                    end
                end
            end

            assign rd_data  = r_rd_data2;
            assign rd_valid = r_v2;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sdp_1ck_be.sv
// Directed bench driving three configurations in lockstep: WRITE_FIRST/latency 2, READ_FIRST/latency 1
// (both DEPTH 8 with sweep) and a DEPTH 6, no-sweep, latency 2 instance for out-of-range behaviour.
module tb_bram_sdp_1ck_be;

    localparam int DW = 64;
    localparam int NB = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    logic [DW-1:0] wf_rd_data, rf_rd_data, oo_rd_data;
    logic          wf_rd_valid, rf_rd_valid, oo_rd_valid;
    logic          wf_busy, rf_busy, oo_busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_sdp_1ck_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(8), .READ_LATENCY(2),
                      .COLLISION("WRITE_FIRST"), .CLEAR_ON_RESET(1'b1)) u_wf (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(wf_rd_data),
        .rd_valid(wf_rd_valid), .init_busy(wf_busy));

    bram_sdp_1ck_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(8), .READ_LATENCY(1),
                      .COLLISION("READ_FIRST"), .CLEAR_ON_RESET(1'b1)) u_rf (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rf_rd_data),
        .rd_valid(rf_rd_valid), .init_busy(rf_busy));

    bram_sdp_1ck_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .DEPTH(6), .READ_LATENCY(2),
                      .COLLISION("WRITE_FIRST"), .CLEAR_ON_RESET(1'b0)) u_oo (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(oo_rd_data),
        .rd_valid(oo_rd_valid), .init_busy(oo_busy));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request cycle; for a read, checks the latency-1 result then the latency-2 results.
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [NB-1:0] be,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic [DW-1:0] e_wf, input logic [DW-1:0] e_rf,
                      input logic [DW-1:0] e_oo, input string tag);
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
        @(negedge clk);
        wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
        if (re) begin
            check({tag, "_rf_valid"}, 64'(rf_rd_valid), 64'd1);
            check({tag, "_rf_data"}, rf_rd_data, e_rf);
            check({tag, "_wf_early"}, 64'(wf_rd_valid), 64'd0);
            @(negedge clk);
            check({tag, "_rf_done"}, 64'(rf_rd_valid), 64'd0);
            check({tag, "_wf_valid"}, 64'(wf_rd_valid), 64'd1);
            check({tag, "_wf_data"}, wf_rd_data, e_wf);
            check({tag, "_oo_valid"}, 64'(oo_rd_valid), 64'd1);
            check({tag, "_oo_data"}, oo_rd_data, e_oo);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        op(1'b1, a, be, d, 1'b0, '0, '0, '0, '0, "wr");
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e_wf, input logic [DW-1:0] e_rf,
                      input logic [DW-1:0] e_oo, input string tag);
        op(1'b0, '0, '0, '0, 1'b1, a, e_wf, e_rf, e_oo, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        int            n_wf;
        int            n_rf;
        logic          seen_valid;
        logic [DW-1:0] exp_tab [6];

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_wf_busy", 64'(wf_busy), 64'd1);
        check("rst_oo_busy", 64'(oo_busy), 64'd1);
        check("rst_wf_valid", 64'(wf_rd_valid), 64'd0);
        check("rst_rf_valid", 64'(rf_rd_valid), 64'd0);
        check("rst_wf_data", wf_rd_data, 64'd0);
        check("rst_rf_data", rf_rd_data, 64'd0);
        check("rst_oo_data", oo_rd_data, 64'd0);

        // First sweep: exactly DEPTH busy cycles; the no-sweep instance is ready at once
        rst_n = 1'b1;
        #1;
        check("oo_no_sweep", 64'(oo_busy), 64'd0);
        n_wf = 0; n_rf = 0;
        for (int c = 0; c < 100; c++) begin
            if (!wf_busy && !rf_busy) break;
            if (wf_busy) n_wf++;
            if (rf_busy) n_rf++;
            @(negedge clk);
        end
        check("sweep1_wf_cycles", 64'(n_wf), 64'd8);
        check("sweep1_rf_cycles", 64'(n_rf), 64'd8);

        for (int i = 0; i < 6; i++) wr(AW'(i), 8'hFF, 64'(10 + i));

        // Back-to-back reads of 0,1,2
        rd_en = 1'b1; rd_addr = 3'd0;
        @(negedge clk);
        check("tp_n1_rf_valid", 64'(rf_rd_valid), 64'd1);
        check("tp_n1_rf_data", rf_rd_data, 64'd10);
        check("tp_n1_wf_valid", 64'(wf_rd_valid), 64'd0);
        rd_addr = 3'd1;
        @(negedge clk);
        check("tp_n2_rf_data", rf_rd_data, 64'd11);
        check("tp_n2_wf_valid", 64'(wf_rd_valid), 64'd1);
        check("tp_n2_wf_data", wf_rd_data, 64'd10);
        check("tp_n2_oo_data", oo_rd_data, 64'd10);
        rd_addr = 3'd2;
        @(negedge clk);
        check("tp_n3_rf_data", rf_rd_data, 64'd12);
        check("tp_n3_wf_valid", 64'(wf_rd_valid), 64'd1);
        check("tp_n3_wf_data", wf_rd_data, 64'd11);
        check("tp_n3_oo_data", oo_rd_data, 64'd11);
        rd_en = 1'b0;
        @(negedge clk);
        check("tp_n4_rf_valid", 64'(rf_rd_valid), 64'd0);
        check("tp_n4_rf_hold", rf_rd_data, 64'd12);
        check("tp_n4_wf_valid", 64'(wf_rd_valid), 64'd1);
        check("tp_n4_wf_data", wf_rd_data, 64'd12);
        check("tp_n4_oo_data", oo_rd_data, 64'd12);
        @(negedge clk);
        check("tp_n5_wf_valid", 64'(wf_rd_valid), 64'd0);
        check("tp_n5_wf_hold", wf_rd_data, 64'd12);

        // Byte enables, including an all-zero mask
        wr(3'd5, 8'hFF, 64'h1122334455667788);
        wr(3'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        rd(3'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "be");
        wr(3'd5, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        rd(3'd5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "be0");

        // Same-address collision, then the following read sees the new data everywhere
        wr(3'd2, 8'hFF, 64'h0);
        op(1'b1, 3'd2, 8'h01, 64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd2,
           64'h00000000000000FF, 64'h0, 64'h00000000000000FF, "coll");
        rd(3'd2, 64'hFF, 64'hFF, 64'hFF, "after_coll");

        // Out of range for the DEPTH-6 instance only
        wr(3'd7, 8'hFF, 64'h5);
        rd(3'd7, 64'h5, 64'h5, 64'h0, "oor7");
        rd(3'd6, 64'h0, 64'h0, 64'h0, "oor6");
        exp_tab[0] = 64'd10; exp_tab[1] = 64'd11; exp_tab[2] = 64'hFF;
        exp_tab[3] = 64'd13; exp_tab[4] = 64'd14; exp_tab[5] = 64'h11223344AAAAAAAA;
        for (int i = 0; i < 6; i++) rd(AW'(i), exp_tab[i], exp_tab[i], exp_tab[i], $sformatf("keep%0d", i));

        // Preload a word that the next sweep must clear
        wr(3'd3, 8'hFF, 64'hDEAD);
        rd(3'd3, 64'hDEAD, 64'hDEAD, 64'hDEAD, "pre3");

        // Reset one cycle after a read is issued
        rd_en = 1'b1; rd_addr = 3'd1;
        @(negedge clk);
        rd_en = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrd_wf_valid", 64'(wf_rd_valid), 64'd0);
        check("midrd_rf_valid", 64'(rf_rd_valid), 64'd0);
        @(negedge clk);
        check("midrd_wf_data", wf_rd_data, 64'd0);
        check("midrd_rf_data", rf_rd_data, 64'd0);

        // Reset again at sweep cycle 4, then a full sweep with requests held on (dropped)
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd3; wr_be = 8'hFF; wr_data = 64'hBEEF;
        rd_en = 1'b1; rd_addr = 3'd3;
        rst_n = 1'b1;
        #1;
        n_wf = 0; n_rf = 0; seen_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!wf_busy && !rf_busy) break;
            if (wf_busy) n_wf++;
            if (rf_busy) n_rf++;
            seen_valid = seen_valid | wf_rd_valid | rf_rd_valid;
            @(negedge clk);
        end
        wr_en = 1'b0; wr_be = '0; rd_en = 1'b0;
        check("sweep2_wf_cycles", 64'(n_wf), 64'd8);
        check("sweep2_rf_cycles", 64'(n_rf), 64'd8);
        check("sweep2_oo_busy", 64'(oo_busy), 64'd0);
        for (int c = 0; c < 3; c++) begin
            seen_valid = seen_valid | wf_rd_valid | rf_rd_valid;
            @(negedge clk);
        end
        check("no_stale_valid", 64'(seen_valid), 64'd0);

        rd(3'd3, 64'h0, 64'h0, 64'hBEEF, "swept3");
        rd(3'd7, 64'h0, 64'h0, 64'h0, "swept7");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
